dm_resp: RTL and testbench

Data-memory responder for the 5-stage MIPS core: the target side of the core's load/store port. It accepts one word-aligned load or store request at a time over a valid/ready handshake and applies byte-enabled writes to a 4 KB word array. After a programmable number of wait states it returns read data or an error flag over a second valid/ready handshake. The block replaces the zero-latency data memory, so the pipeline can be exercised against realistic memory timing.

---
 rtl/dm_resp_pkg.sv | 19 +
 rtl/dm_resp_ram.sv | 47 ++++
 rtl/dm_resp.sv | 148 ++++++++++++++
 tb/tb_dm_resp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// Shared constants and helpers for the data-memory responder.
package dm_resp_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // A request is rejected when it is not word aligned or falls above the array.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dm_resp_ram.sv
// Single-port word array with byte write enables and a registered read port.
// The read register doubles as the response data register, so it can also be
// cleared to present zero for stores, errors and idle.
module dm_resp_ram
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte-enabled write; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Next read-data value: clear wins over a read.
  always_comb begin
    rdata_d = rdata_q;
    if (clr)        rdata_d = '0;
    else if (rd_en) rdata_d = mem[addr];
  end

  // Read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// memory access on the edge that enters RESP.
module dm_resp
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  // Commit-edge view of the request: straight from the port when WAIT=0
  // (commit happens on the accept edge), otherwise from the latch.
  logic [31:0]       c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_we, c_err;
  logic              commit, ram_wr, ram_rd, ram_clr;

  // Select the request fields seen at the commit edge.
  always_comb begin
    c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    c_be    = (state_q == S_IDLE) ? req_be    : be_q;
    c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    c_err   = addr_err(c_addr, ADDR_W);
  end

  // FSM, wait counter, request latch and response control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;
    ram_wr      = 1'b0;
    ram_rd      = 1'b0;
    ram_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          if (WAIT == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          ram_clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = c_err;
      ram_wr      = !c_err && c_we;
      ram_rd      = !c_err && !c_we;
      ram_clr     = c_err || c_we;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dm_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .wr_en (ram_wr),
    .rd_en (ram_rd),
    .clr   (ram_clr),
    .be    (c_be),
    .addr  (c_addr[ADDR_W+1:2]),
    .wdata (c_wdata),
    .rdata (rsp_rdata)
  );

  // Held low through reset so nothing is accepted before release.
  assign req_ready = rst && (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Randomized scoreboard bench for dm_resp (WAIT=2, 4 KB array).
module tb_dm_resp;

  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  dm_resp #(.ADDR_W(10), .WAIT(WAITS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] mask;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       expq[$];
  bit [7:0]   mb[int];      // reference memory, byte-addressed, known bytes only
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         hold_cnt = 0;
  bit         rnd_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: 4 KB word array, misaligned or >= 4 KB is an error.
  function automatic exp_t model(input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   w;
    e.rd = 32'h0; e.mask = 32'hFFFF_FFFF; e.acc = 0;
    e.err = (addr % 4 != 0) || (addr >= 32'h1000);
    w = int'(addr / 4);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mb[w*4+i] = wdata[8*i +: 8];
      end else begin
        e.mask = 32'h0;
        for (int i = 0; i < 4; i++)
          if (mb.exists(w*4+i)) begin
            e.rd[8*i +: 8]   = mb[w*4+i];
            e.mask[8*i +: 8] = 8'hFF;
          end
      end
    end
    return e;
  endfunction

  // Drive one request until accepted; optionally record its expected response.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 (addr %h)", addr);
    end else if (push) begin
      e = model(we, be, addr, wdata);
      e.acc = cyc;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_be = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // rsp_ready driver: forced low while hold_cnt runs, else 1 or random.
  always @(posedge clk) begin
    #2;
    if (hold_cnt > 0) begin rsp_ready = 1'b0; hold_cnt--; end
    else rsp_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: latency on each rise, stability while stalled, compare on handshake.
  bit          m_pv = 0, m_hold = 0, m_perr = 0;
  logic [31:0] m_prd = 32'h0;
  exp_t        m_e;
  always @(negedge clk) begin
    if (!rst) begin
      m_pv = 0; m_hold = 0;
    end else begin
      if (rsp_valid && req_ready) chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
      if (m_hold) begin
        chk("stall_valid", {31'h0, rsp_valid}, 32'h1);
        chk("stall_rdata", rsp_rdata, m_prd);
        chk("stall_err", {31'h0, rsp_err}, {31'h0, m_perr});
      end
      if (rsp_valid && !m_pv) begin
        if (expq.size() == 0) chk("spurious_rsp", {31'h0, rsp_valid}, 32'h0);
        else chk("latency", 32'(cyc - expq[0].acc), 32'(WAITS + 1));
      end
      if (rsp_valid && rsp_ready && expq.size() != 0) begin
        m_e = expq.pop_front();
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_e.err});
        chk("rsp_rdata", rsp_rdata & m_e.mask, m_e.rd & m_e.mask);
      end
      m_pv = rsp_valid; m_hold = rsp_valid && !rsp_ready;
      m_prd = rsp_rdata; m_perr = rsp_err;
    end
  end

  initial begin
    logic [31:0] a;
    // Reset phase and idle after release.
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", {31'h0, rsp_err}, 32'h0);
    end
    @(posedge clk); #1; rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("idle_rdata", rsp_rdata, 32'h0);
      chk("idle_err", {31'h0, rsp_err}, 32'h0);
    end
    @(posedge clk); #1;

    // Full-word store then load; partial store merge.
    do_req(1, 4'hF, 32'h010, 32'hDEADBEEF, 1);
    do_req(0, 4'h0, 32'h010, 32'h0, 1);
    do_req(1, 4'hF, 32'h020, 32'hAABBCCDD, 1);
    do_req(1, 4'h5, 32'h020, 32'h11223344, 1);
    do_req(0, 4'h3, 32'h020, 32'h0, 1);
    // Errors leave memory alone; be=0 store is a no-op.
    do_req(0, 4'hF, 32'h013, 32'h0, 1);
    do_req(0, 4'hF, 32'h1000, 32'h0, 1);
    do_req(1, 4'hF, 32'h011, 32'h0BAD0BAD, 1);
    do_req(1, 4'h0, 32'h010, 32'h12345678, 1);
    do_req(0, 4'hF, 32'h010, 32'h0, 1);
    drain();

    // Stall the response of a load; the following request must wait.
    hold_cnt = 8;
    do_req(0, 4'hF, 32'h020, 32'h0, 1);
    do_req(0, 4'hF, 32'h010, 32'h0, 1);
    drain();

    // Reset during WAIT of a store: not committed.
    do_req(1, 4'hF, 32'h030, 32'h0, 1);
    drain();
    do_req(1, 4'hF, 32'h030, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_err", {31'h0, rsp_err}, 32'h0);
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(0, 4'hF, 32'h030, 32'h0, 1);
    drain();

    // Random traffic over a small pool plus error addresses.
    for (int i = 0; i < 8; i++) do_req(1, 4'hF, 32'h40 + 32'(4*i), $urandom, 1);
    rnd_mode = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00} | 32'($urandom_range(1, 3));
        1:       a = ($urandom | 32'h1000) & ~32'h3;
        default: a = 32'h40 + 32'(4 * $urandom_range(0, 7));
      endcase
      do_req(1'($urandom), 4'($urandom), a, $urandom, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
